fetch_unit: RTL and testbench

Program-counter and fetch-sequencing stage that drives `instructionMemory`. It issues word addresses on `AddressBus` and absorbs the memory's one-cycle registered read latency. A 2-entry buffer presents {pc, instruction} pairs to decode over a valid/ready handshake. It also applies branch/jump redirects from later stages and flushes stale fetches.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Program counter and fetch sequencer. Issues word addresses to
//               an instruction memory with a one-cycle registered read. Returned
//               words are collected in a 2-entry {pc, instr} buffer that feeds
//               decode over a valid/ready handshake. Redirects flush all state.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] AddressBus,
    input  logic [15:0] InstructionReg,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instruction,
    output logic [15:0] if_pc
);

    // Program counter and the address whose data arrives on the next edge
    logic [15:0] r_pc;
    logic        r_inflight;
    logic [15:0] r_inflight_pc;

    // Two-entry buffer of fetched {pc, instruction} pairs
    logic [15:0] r_buf_pc    [0:1];
    logic [15:0] r_buf_instr [0:1];
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [1:0]  w_occ;
    logic [1:0]  w_count_next;

    // Occupancy counts the in-flight read so a landing word always has room;
    // a pop in the same cycle frees a slot, which keeps full throughput.
    always_comb begin
        w_pop   = if_valid && if_ready;
        w_occ   = r_count + {1'b0, r_inflight};
        w_issue = fetch_enable && !redirect_valid && ((w_occ < 2'd2) || w_pop);
        w_push  = r_inflight && !redirect_valid;
    end

    // Next buffer occupancy from the push/pop pair of this cycle
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // PC advance, in-flight tracking and redirect
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0000;
        end else if (redirect_valid) begin
            r_pc       <= redirect_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + 16'd1;
                r_inflight_pc <= r_pc;
            end
        end
    end

    // Buffer push/pop; a redirect empties it regardless of any handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_pc[0]    <= 16'h0000;
            r_buf_pc[1]    <= 16'h0000;
            r_buf_instr[0] <= 16'h0000;
            r_buf_instr[1] <= 16'h0000;
            r_count        <= 2'd0;
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
        end else if (redirect_valid) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_pc[r_tail]    <= r_inflight_pc;
                r_buf_instr[r_tail] <= InstructionReg;
                r_tail              <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= w_count_next;
        end
    end

    // Outputs come straight from registers; no path from InstructionReg
    always_comb begin
        AddressBus     = r_pc;
        if_valid       = (r_count != 2'd0);
        if_pc          = r_buf_pc[r_head];
        if_instruction = r_buf_instr[r_head];
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a behavioural
//               one-cycle registered instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        if_ready;

    logic [15:0] addr_a, instr_a, if_instr_a, if_pc_a;
    logic        if_valid_a;
    logic [15:0] addr_b, instr_b, if_instr_b, if_pc_b;
    logic        if_valid_b;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Memory contents: every word is its address XOR a fixed pattern
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // One-cycle registered read memories
    always @(posedge clock) instr_a <= mem_word(addr_a);
    always @(posedge clock) instr_b <= mem_word(addr_b);

    fetch_unit #(.RESET_PC(16'h0000)) dut_a (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_enable    (fetch_enable),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .AddressBus      (addr_a),
        .InstructionReg  (instr_a),
        .if_valid        (if_valid_a),
        .if_ready        (if_ready),
        .if_instruction  (if_instr_a),
        .if_pc           (if_pc_a)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_b (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_enable    (fetch_enable),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .AddressBus      (addr_b),
        .InstructionReg  (instr_b),
        .if_valid        (if_valid_b),
        .if_ready        (if_ready),
        .if_instruction  (if_instr_b),
        .if_pc           (if_pc_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head_a(input string tag, input logic [15:0] pc);
        chk({tag, " valid"}, {15'd0, if_valid_a}, 16'd1);
        chk({tag, " pc"}, if_pc_a, pc);
        chk({tag, " instr"}, if_instr_a, mem_word(pc));
    endtask

    task automatic head_b(input string tag, input logic [15:0] pc);
        chk({tag, " valid"}, {15'd0, if_valid_b}, 16'd1);
        chk({tag, " pc"}, if_pc_b, pc);
        chk({tag, " instr"}, if_instr_b, mem_word(pc));
    endtask

    task automatic empty_a(input string tag, input logic [15:0] addr);
        chk({tag, " valid"}, {15'd0, if_valid_a}, 16'd0);
        chk({tag, " addr"}, addr_a, addr);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset, with a redirect held that must be ignored
        reset_n         = 1'b0;
        fetch_enable    = 1'b1;
        if_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 16'h0033;
        tick();
        tick();
        empty_a("reset_a", 16'h0000);
        chk("reset_a if_pc", if_pc_a, 16'h0000);
        chk("reset_a if_instr", if_instr_a, 16'h0000);
        chk("reset_b addr", addr_b, 16'hFFFE);
        chk("reset_b valid", {15'd0, if_valid_b}, 16'd0);
        reset_n        = 1'b1;
        redirect_valid = 1'b0;

        // E1: RESET_PC issued, nothing valid yet
        tick();
        empty_a("e1", 16'h0001);
        chk("e1_b valid", {15'd0, if_valid_b}, 16'd0);

        // E2..E5: one instruction per cycle; second instance wraps
        tick(); head_a("e2", 16'h0000); head_b("wrap0", 16'hFFFE);
        tick(); head_a("e3", 16'h0001); head_b("wrap1", 16'hFFFF);
        tick(); head_a("e4", 16'h0002); head_b("wrap2", 16'h0000);
        tick(); head_a("e5", 16'h0003); head_b("wrap3", 16'h0001);

        // Stall 5 cycles: word 4 lands, buffer full, pc frozen at 5
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            head_a("stall", 16'h0003);
            chk("stall addr", addr_a, 16'h0005);
        end
        if_ready = 1'b1;
        tick(); head_a("resume4", 16'h0004);
        tick(); head_a("resume5", 16'h0005);
        tick(); head_a("resume6", 16'h0006);

        // Redirect in steady stream, coincident with the pop of word 6
        redirect_valid  = 1'b1;
        redirect_target = 16'h0005;
        tick();
        empty_a("redir_a t0", 16'h0005);
        redirect_valid = 1'b0;
        tick();
        empty_a("redir_a t1", 16'h0006);
        tick(); head_a("redir_a t2", 16'h0005);
        tick(); head_a("redir_a t3", 16'h0006);
        tick(); head_a("redir_a t4", 16'h0007);

        // Redirect with a full buffer under backpressure
        if_ready = 1'b0;
        tick(); head_a("fill", 16'h0007);
        chk("fill addr", addr_a, 16'h0009);
        tick(); head_a("full", 16'h0007);
        redirect_valid  = 1'b1;
        redirect_target = 16'h0040;
        tick();
        empty_a("redir_b t0", 16'h0040);
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        tick();
        empty_a("redir_b t1", 16'h0041);
        tick(); head_a("redir_b t2", 16'h0040);
        tick(); head_a("redir_b t3", 16'h0041);

        // Back-to-back redirects: the last wins
        redirect_valid  = 1'b1;
        redirect_target = 16'h0100;
        tick();
        empty_a("b2b first", 16'h0100);
        redirect_target = 16'h0200;
        tick();
        empty_a("b2b second", 16'h0200);
        redirect_valid = 1'b0;
        tick();
        empty_a("b2b t1", 16'h0201);
        tick(); head_a("b2b t2", 16'h0200);

        // fetch_enable low for 4 cycles: in-flight 0x201 lands and drains
        fetch_enable = 1'b0;
        tick(); head_a("fe_off1", 16'h0201);
        chk("fe_off1 addr", addr_a, 16'h0202);
        tick(); empty_a("fe_off2", 16'h0202);
        tick(); empty_a("fe_off3", 16'h0202);
        tick(); empty_a("fe_off4", 16'h0202);
        fetch_enable = 1'b1;
        tick(); empty_a("fe_on1", 16'h0203);
        tick(); head_a("fe_on2", 16'h0202);
        tick(); head_a("fe_on3", 16'h0203);

        // Redirect with a pop and fetch disabled in the same cycle
        redirect_valid  = 1'b1;
        redirect_target = 16'h0300;
        fetch_enable    = 1'b0;
        tick();
        empty_a("rdfe t0", 16'h0300);
        redirect_valid = 1'b0;
        tick(); empty_a("rdfe t1", 16'h0300);
        tick(); empty_a("rdfe t2", 16'h0300);
        fetch_enable = 1'b1;
        tick(); empty_a("rdfe t3", 16'h0301);
        tick(); head_a("rdfe t4", 16'h0300);

        // Asynchronous reset mid-operation, no clock edge involved
        #3 reset_n = 1'b0;
        #1;
        empty_a("async rst", 16'h0000);
        chk("async rst if_pc", if_pc_a, 16'h0000);
        #1 reset_n = 1'b1;
        tick(); empty_a("post rst e1", 16'h0001);
        tick(); head_a("post rst e2", 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
